// File: rtl/servo_position_ramp_if.sv
// rtl/servo_position_ramp_if.sv - target-position valid/ready handshake bundle
interface servo_position_ramp_if;
    logic       i_Pos_Valid;
    logic [7:0] i_Pos;
    logic       o_Pos_Ready;

    modport master (
        output i_Pos_Valid,
        output i_Pos,
        input  o_Pos_Ready
    );

    modport slave (
        input  i_Pos_Valid,
        input  i_Pos,
        output o_Pos_Ready
    );
endinterface

// File: rtl/servo_position_ramp.sv
// rtl/servo_position_ramp.sv - 8-bit position to servo pulse width with per-frame slew and frame tick
// Optional build macro SERVO_RAMP_SLEW_EN: defined = slew-limited ramp, undefined = single-step jump.
module servo_position_ramp #(
    parameter int CLKS_PER_FRAME = 2000000,
    parameter int MIN_PULSE      = 100000,
    parameter int STEP_SCALE     = 392,
    parameter int SLEW_STEP      = 3920
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    servo_position_ramp_if.slave  pos_if,
    output logic [23:0]           o_Control_Range,
    output logic                  o_Frame_Tick,
    output logic                  o_At_Target
);

    localparam int CNT_W = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SLEW = 2'd2;

    localparam logic [23:0] MIN_W     = 24'(MIN_PULSE);
    localparam logic [23:0] RESET_W   = 24'(MIN_PULSE + 128 * STEP_SCALE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_FRAME - 1);
`ifdef SERVO_RAMP_SLEW_EN
    localparam logic [23:0] STEP_W    = 24'(SLEW_STEP);
`else
    // Step saturated above any reachable distance, so each tick lands on the target.
    localparam logic [23:0] STEP_W    = 24'hFF_FFFF | 24'(SLEW_STEP);
`endif

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       state_q,  state_d;
    logic [7:0]       pos_q,    pos_d;
    logic [23:0]      target_q, target_d;
    logic [23:0]      range_q,  range_d;
    logic             at_q,     at_d;

    logic             frame_tick_w;
    logic             ready_w;
    logic             xfer_w;
    logic [16:0]      prod_w;
    logic [23:0]      dist_w;
    logic [23:0]      slew_next_w;

    assign frame_tick_w = (cnt_q == LAST_CNT);
    assign ready_w      = (state_q != ST_CALC);
    assign xfer_w       = pos_if.i_Pos_Valid && ready_w;
    assign prod_w       = 17'(pos_q) * 17'(STEP_SCALE);

    // Subtraction direction follows the magnitude compare, so the distance never wraps.
    always_comb begin
        dist_w      = '0;
        slew_next_w = target_q;
        if (target_q > range_q) begin
            dist_w      = target_q - range_q;
            slew_next_w = (dist_w <= STEP_W) ? target_q : range_q + STEP_W;
        end else begin
            dist_w      = range_q - target_q;
            slew_next_w = (dist_w <= STEP_W) ? target_q : range_q - STEP_W;
        end
    end

    always_comb begin
        cnt_d    = frame_tick_w ? '0 : cnt_q + CNT_W'(1);
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        range_d  = range_q;
        at_d     = at_q;

        case (state_q)
            ST_CALC: begin
                target_d = MIN_W + {7'd0, prod_w};
                state_d  = ST_SLEW;
            end
            ST_SLEW: begin
                if (frame_tick_w) begin
                    range_d = slew_next_w;
                end
                if (range_q == target_q) begin
                    state_d = ST_IDLE;
                    at_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new target preempts settling; the ramp resumes from the current width.
        if (xfer_w) begin
            pos_d   = pos_if.i_Pos;
            state_d = ST_CALC;
            at_d    = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            pos_q    <= 8'd128;
            target_q <= RESET_W;
            range_q  <= RESET_W;
            at_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            range_q  <= range_d;
            at_q     <= at_d;
        end
    end

    assign pos_if.o_Pos_Ready = ready_w;
    assign o_Control_Range    = range_q;
    assign o_Frame_Tick       = frame_tick_w;
    assign o_At_Target        = at_q;

endmodule

// File: doc/servo_position_ramp.md
# servo_position_ramp

Converts an 8-bit servo position command into the 24-bit pulse-width count (`o_Control_Range`, in clocks) consumed directly by `Servo_Control`. It sits immediately upstream of `Servo_Control`, which reads `o_Control_Range` as its `i_Control_Range` input. The block accepts targets over a valid/ready handshake and maps each position linearly onto the 1 ms–2 ms pulse range. It applies a per-frame slew limit so the servo ramps toward a new target instead of jumping. It also generates the 20 ms frame tick that paces those updates.

## Interface
- `CLKS_PER_FRAME`, default 2000000: clocks per servo frame (20 ms at 100 MHz).
- `MIN_PULSE`, default 100000: pulse width for position 0 (1 ms).
- `STEP_SCALE`, default 392: clocks per position LSB. Position 255 maps to 199960.
- `SLEW_STEP`, default 3920: maximum change of `o_Control_Range` per frame tick.
- `i_Clk`, input, 1 bit: system clock, 100 MHz.
- `i_Rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `i_Pos_Valid`, input, 1 bit: a target position is offered.
- `i_Pos`, input, 8 bits: target position, 0..255.
- `o_Pos_Ready`, output, 1 bit: the block can accept a target this cycle.
- `o_Control_Range`, output, 24 bits: pulse width in clocks, sent to `Servo_Control`.
- `o_Frame_Tick`, output, 1 bit: one-cycle pulse at the end of each frame.
- `o_At_Target`, output, 1 bit: `o_Control_Range` equals the latched target.

## Operation
- **Reset values:**
  - `o_Control_Range` = `r_Target` = MIN_PULSE + 128·STEP_SCALE (150176 with defaults).
  - `o_Pos_Ready` = 1, `o_At_Target` = 1, `o_Frame_Tick` = 0.
  - Frame counter = 0, state = IDLE.
- **Frame counter:** counts 0..CLKS_PER_FRAME−1 and wraps to 0. `o_Frame_Tick` is 1 exactly on the cycle the counter holds CLKS_PER_FRAME−1. The counter runs freely in every state.
- **Handshake:**
  - A transfer occurs on a rising edge where `i_Pos_Valid` and `o_Pos_Ready` are both 1.
  - `i_Pos` is captured on that edge.
  - Valid while ready is 0 is ignored. Nothing is queued.
- **States:**
  - **IDLE:** `o_Pos_Ready`=1. A transfer moves to CALC.
  - **CALC:** `o_Pos_Ready`=0, for one cycle. The block computes `r_Target` = MIN_PULSE + pos·STEP_SCALE (17-bit product, zero-extended to 24 bits), then moves to SLEW.
  - **SLEW:** `o_Pos_Ready`=1.
    - On each frame tick: if |r_Target − o_Control_Range| ≤ SLEW_STEP, `o_Control_Range` is set to `r_Target`. Otherwise it moves SLEW_STEP toward `r_Target`.
    - Moves to IDLE on the first cycle where `o_Control_Range` = `r_Target`. This includes the cycle immediately after CALC when the new target equals the current value.
    - A transfer in SLEW moves to CALC. The ramp continues from the current `o_Control_Range` toward the new target.
- **`o_At_Target`:** registered. Cleared on every transfer edge; set on the edge that enters IDLE.
- **Arithmetic:** all comparisons are unsigned 24-bit, with the subtraction direction chosen by magnitude compare. No wrap-around is possible, because the maximum value is 199960.
- **Frame tick during CALC:** that frame's update is skipped and `o_Control_Range` holds.
- **Mid-operation reset:** all outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- Transfer at edge N: CALC is entered at N and `r_Target` is valid after edge N+1.
- The first possible change of `o_Control_Range` is at the first frame tick at or after edge N+2.
- `o_Control_Range` changes only on tick edges. It is stable for a full frame, so `Servo_Control` sees a constant width within each period.
- The first `o_Frame_Tick` appears CLKS_PER_FRAME−1 cycles after reset release.
- A ramp of distance D takes ceil(D / SLEW_STEP) ticks.

## Configuration
- Macro: `SERVO_RAMP_SLEW_EN`.
  - **Defined:** slew limiting as described in Operation.
  - **Undefined:** in SLEW, the first frame tick sets `o_Control_Range` = `r_Target` in a single step, and `SLEW_STEP` is unused.
- The handshake, CALC latency and frame-tick pacing are identical in both builds.

## Test plan
All scenarios use CLKS_PER_FRAME=1000 for simulation speed, with the other parameters at their defaults.
1. **Reset:** assert `i_Rst_n`=0 mid-cycle -> outputs immediately read `o_Control_Range`=150176, ready=1, at_target=1, tick=0. After release, the first tick occurs 999 cycles later.
2. **Full ramp (macro defined):** transfer pos=255 -> `r_Target`=199960. After 12 ticks the output is 197216; the 13th tick gives 199960; `o_At_Target` rises the following cycle.
3. **Retarget mid-ramp:** after 3 ticks toward 255 (output 161936), transfer pos=128 -> the output ramps down by 3920 per tick and reaches 150176 after exactly 3 further ticks.
4. **Handshake:** `i_Pos_Valid`=1 with pos=0 for exactly the one cycle while ready=0 (CALC) -> not accepted; `r_Target` and the ramp are unchanged.
5. **Macro undefined:** transfer pos=0 -> at the first tick after CALC, `o_Control_Range` = 100000 in one step.
6. **Same target:** transfer pos=128 from reset -> `o_At_Target` drops for exactly 2 cycles, no output change, back to IDLE.
